loop_playback_reader: RTL and testbench
=======================================

LOOP_PLAYBACK_READER -- requirements
Module: loop_playback_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning sample/readdata width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of 2), meaning prefetch buffer entries.
REQ-004 clk  in  1  system clock (50 MHz); one clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 play  in  1  level; 1 = loop playback active.
REQ-007 start_addr  in  ADDR_W  first word of loop; sampled on IDLE->RUN.
REQ-008 end_addr  in  ADDR_W  last word of loop (inclusive); sampled on IDLE->RUN.
REQ-009 sample_req  in  1  one-cycle pulse; audio path wants next sample.
REQ-010 avm_address  out  ADDR_W  SDRAM read address.
REQ-011 avm_read  out  1  read request.
REQ-012 avm_waitrequest  in  1  slave stall; request accepted when avm_read=1 and avm_waitrequest=0.
REQ-013 avm_readdata  in  DATA_W  read return data.
REQ-014 avm_readdatavalid  in  1  avm_readdata valid this cycle; returns in issue order.
REQ-015 sample_out  out  DATA_W  sample delivered to audio out.
REQ-016 sample_valid  out  1  one-cycle pulse; sample_out updated.
REQ-017 underrun  out  1  one-cycle pulse; sample_req with empty FIFO.
REQ-018 busy  out  1  1 in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-020 IDLE->RUN when play=1: latch start_addr/end_addr; if end_addr<start_addr, use end=start; set next address to start.
REQ-021 RUN: assert avm_read whenever (fifo_count + outstanding) < FIFO_DEPTH.
REQ-022 While avm_read=1 and avm_waitrequest=1, avm_address and avm_read SHALL hold stable.
REQ-023 On acceptance, outstanding +1 and address advances by 1; after latched end, address wraps to latched start.
REQ-024 Each avm_readdatavalid SHALL push avm_readdata into FIFO and decrement outstanding; accept and issue in same cycle leaves outstanding unchanged.
REQ-025 The credit rule SHALL guarantee the FIFO never overflows; readdatavalid is never back-pressured.
REQ-026 sample_req with FIFO non-empty: pop head; next cycle sample_out = head, sample_valid = 1.
REQ-027 sample_req with FIFO empty: next cycle sample_out = 0, underrun = 1, sample_valid = 0.
REQ-028 Push and pop in the same cycle SHALL leave fifo_count unchanged; data ordering preserved, including push into an empty FIFO.
REQ-029 RUN->DRAIN when play=0: avm_read drops immediately, including while avm_waitrequest=1, which abandons the unaccepted request.
REQ-030 DRAIN: accept returning data, then discard it; when outstanding=0, flush FIFO and go to IDLE.
REQ-031 DRAIN/IDLE: sample_req yields sample_out=0 with sample_valid=1 (silence) and no underrun.
REQ-032 play=1 during DRAIN SHALL be ignored until IDLE is reached; restart begins at start_addr.
REQ-033 outstanding counter SHALL be log2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.

Reset
REQ-034 On reset=0 asynchronously: state=IDLE, avm_read=0, avm_address=0, sample_out=0, sample_valid=0, underrun=0, busy=0, FIFO empty, outstanding=0.
REQ-035 Reset mid-transfer SHALL drop in-flight reads; readdatavalid in the first cycle after release SHALL be ignored (outstanding=0).

Verification
REQ-036 start=0x100, end=0x103, play=1, zero-wait slave, 2-cycle latency -> reads 0x100..0x103,0x100,...; FIFO fills to 8; no 9th outstanding request.
REQ-037 waitrequest held 5 cycles on 0x102 -> avm_address stays 0x102 with avm_read=1 throughout; one acceptance only.
REQ-038 sample_req every 1042 cycles, slave returns addr as data -> sample_out sequence 0x100,0x101,0x102,0x103,0x100; never underrun.
REQ-039 slave withholds readdatavalid, sample_req pulsed -> underrun=1 one cycle, sample_out=0.
REQ-040 play drops with 3 reads outstanding -> avm_read=0 next cycle; busy stays 1 until third readdatavalid; then IDLE, FIFO empty.
REQ-041 end=0x0F0 < start=0x100 -> reads repeat 0x100 only; reset asserted mid-RUN -> all outputs at REQ-034 values immediately.

Source files
------------

// File: rtl/loop_playback_reader.sv
// rtl/loop_playback_reader.sv - looping SDRAM sample reader with credit-limited prefetch FIFO
// Reads start..end repeatedly over an Avalon-MM read master and hands samples to the audio path on request.
module loop_playback_reader #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              sample_req,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   sample_out_q, sample_out_d;
  logic                sample_valid_q, sample_valid_d;
  logic                underrun_q, underrun_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic credit, read_req, accept, rdv_ok, push, pop;

  // Credits count both buffered and in-flight words, so returning data always has a slot.
  always_comb begin
    credit   = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_L;
    read_req = (state_q == S_RUN) && credit;
    accept   = read_req && !avm_waitrequest;
    rdv_ok   = avm_readdatavalid && (outst_q != '0);
    push     = rdv_ok && (state_q == S_RUN);
    pop      = sample_req && (state_q == S_RUN) && (count_q != '0);
  end

  always_comb begin
    state_d        = state_q;
    start_d        = start_q;
    end_d          = end_q;
    addr_d         = addr_q;
    outst_d        = outst_q;
    count_d        = count_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    underrun_d     = 1'b0;

    unique case ({accept, rdv_ok})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (accept) addr_d = (addr_q == end_q) ? start_q : addr_q + ADDR_W'(1);

    if (sample_req) begin
      if (state_q != S_RUN) begin
        sample_out_d   = '0;
        sample_valid_d = 1'b1;
      end else if (count_q != '0) begin
        sample_out_d   = mem_q[rd_ptr_q];
        sample_valid_d = 1'b1;
      end else begin
        sample_out_d = '0;
        underrun_d   = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d = S_RUN;
          start_d = start_addr;
          end_d   = (end_addr < start_addr) ? start_addr : end_addr;
          addr_d  = start_addr;
        end
      end
      S_RUN: begin
        if (!play) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outst_d == '0) begin
          state_d  = S_IDLE;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      start_q        <= '0;
      end_q          <= '0;
      addr_q         <= '0;
      outst_q        <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      end_q          <= end_d;
      addr_q         <= addr_d;
      outst_q        <= outst_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= avm_readdata;
  end

  assign avm_address  = addr_q;
  assign avm_read     = read_req;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_loop_playback_reader.sv
// tb/tb_loop_playback_reader.sv - scoreboard bench for loop_playback_reader
module tb_loop_playback_reader;
  localparam int AW = 25;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          sample_req = 1'b0;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          underrun;
  logic          busy;

  int checks = 0;
  int errors = 0;

  loop_playback_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .play(play),
    .start_addr(start_addr), .end_addr(end_addr), .sample_req(sample_req),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .underrun(underrun), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } rd_t;

  logic [AW-1:0] exp_addr[$];
  logic [DW:0]   exp_smp[$];
  rd_t           pipe[$];
  rd_t           r;
  logic [AW-1:0] ea;
  logic [DW:0]   es;
  int  cyc = 0, out_tb = 0, delivered = 0, stall_cnt = 0;
  bit  stall_en = 0, hold_rdv = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW:0] smp(input logic u, input logic [DW-1:0] d);
    return {u, d};
  endfunction

  // Slave model: 2-cycle read latency, returns the address as data, optional stall and hold.
  always @(negedge clk) begin
    cyc++;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    avm_waitrequest   = 1'b0;
    if (!reset) begin
      pipe.delete();
      out_tb = 0;
    end else begin
      if (!hold_rdv && pipe.size() > 0 && pipe[0].due <= cyc) begin
        r = pipe.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = DW'(r.a);
        out_tb--;
        delivered++;
      end
      if (stall_cnt > 0 && stall_cnt < 5) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
        checks++;
        if (!(avm_read === 1'b1 && avm_address === AW'(32'h102))) begin
          errors++;
          $display("FAIL stall_hold read=%b addr=%0h required read=1 addr=102", avm_read, avm_address);
        end
      end else if (stall_en && avm_read && avm_address == AW'(32'h102)) begin
        avm_waitrequest = 1'b1;
        stall_cnt       = 1;
        stall_en        = 0;
      end
      if (avm_read && !avm_waitrequest) begin
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL extra_read addr=%0h required no read", avm_address);
        end else begin
          ea = exp_addr.pop_front();
          if (avm_address !== ea) begin
            errors++;
            $display("FAIL read_addr actual=%0h required=%0h", avm_address, ea);
          end
        end
        out_tb++;
        checks++;
        if (out_tb > 8) begin
          errors++;
          $display("FAIL outstanding actual=%0d required<=8", out_tb);
        end
        pipe.push_back('{avm_address, cyc + 2});
      end
    end
  end

  // Sample monitor: pops the scoreboard on every delivered sample or underrun.
  always @(negedge clk) begin
    if (reset && (sample_valid || underrun)) begin
      checks++;
      if (exp_smp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample valid=%b underrun=%b data=%0h", sample_valid, underrun, sample_out);
      end else begin
        es = exp_smp.pop_front();
        if ({underrun, sample_out} !== es || sample_valid === underrun) begin
          errors++;
          $display("FAIL sample actual underrun=%b valid=%b data=%0h required underrun=%b data=%0h",
                   underrun, sample_valid, sample_out, es[DW], es[DW-1:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input logic [DW:0] e);
    @(negedge clk);
    exp_smp.push_back(e);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
  endtask

  initial begin
    int n;
    tick(3);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_sample", sample_out, 0);
    reset = 1'b1;
    tick(2);

    // Loop 0x100..0x103 with a 5-cycle stall on 0x102, then paced sample requests.
    start_addr = AW'(32'h100);
    end_addr   = AW'(32'h103);
    for (int i = 0; i < 13; i++) exp_addr.push_back(AW'(32'h100 + i % 4));
    stall_en = 1;
    play     = 1'b1;
    tick(60);
    chk("fill_reads_left", exp_addr.size(), 5);
    chk("full_no_read", avm_read, 0);
    chk("fill_returned", out_tb, 0);
    chk("busy_run", busy, 1);
    for (int i = 0; i < 5; i++) begin
      req(smp(1'b0, DW'(32'h100 + i % 4)));
      tick(1040);
    end
    chk("loop_reads_done", exp_addr.size(), 0);
    chk("loop_samples_done", exp_smp.size(), 0);

    // Three reads in flight when play drops.
    hold_rdv = 1;
    for (int i = 1; i <= 3; i++) begin
      exp_addr.push_back(AW'(32'h100 + i));
      req(smp(1'b0, DW'(32'h100 + i)));
    end
    tick(3);
    chk("outstanding_3", out_tb, 3);
    play = 1'b0;
    @(negedge clk);
    chk("drain_read_off", avm_read, 0);
    chk("drain_busy", busy, 1);
    req(smp(1'b0, '0));
    tick(5);
    chk("drain_busy_hold", busy, 1);
    delivered = 0;
    hold_rdv  = 0;
    n = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #2;
      if (!busy) begin
        n = delivered - (avm_readdatavalid ? 1 : 0);
        break;
      end
    end
    chk("drain_idle_after_3rdv", n, 3);
    req(smp(1'b0, '0));
    chk("idle_read_off", avm_read, 0);

    // Fresh loop with returns withheld: underrun, then FIFO must hold only new data.
    start_addr = AW'(32'h300);
    end_addr   = AW'(32'h307);
    hold_rdv   = 1;
    for (int i = 0; i < 8; i++) exp_addr.push_back(AW'(32'h300 + i));
    play = 1'b1;
    tick(15);
    chk("hold_reads_done", exp_addr.size(), 0);
    chk("hold_no_9th", avm_read, 0);
    req(smp(1'b1, '0));
    hold_rdv = 0;
    tick(15);
    chk("hold_returned", out_tb, 0);
    exp_addr.push_back(AW'(32'h300));
    req(smp(1'b0, DW'(32'h300)));
    tick(5);
    play = 1'b0;
    tick(20);
    chk("second_idle", busy, 0);

    // end below start collapses to a single word; then reset mid-run.
    start_addr = AW'(32'h100);
    end_addr   = AW'(32'h0F0);
    for (int i = 0; i < 8; i++) exp_addr.push_back(AW'(32'h100));
    play = 1'b1;
    tick(20);
    chk("single_reads_done", exp_addr.size(), 0);
    chk("single_full", avm_read, 0);
    exp_addr.push_back(AW'(32'h100));
    req(smp(1'b0, DW'(32'h100)));
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_read", avm_read, 0);
    chk("mid_rst_addr", avm_address, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sample", sample_out, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_underrun", underrun, 0);
    play = 1'b0;
    tick(2);
    start_addr = AW'(32'h200);
    end_addr   = AW'(32'h201);
    for (int i = 0; i < 9; i++) exp_addr.push_back(AW'(32'h200 + i % 2));
    reset = 1'b1;
    play  = 1'b1;
    #1;
    avm_readdatavalid = 1'b1;
    avm_readdata      = DW'(32'hDEAD);
    tick(20);
    req(smp(1'b0, DW'(32'h200)));
    tick(5);
    play = 1'b0;
    tick(20);
    chk("final_reads_done", exp_addr.size(), 0);
    chk("final_samples_done", exp_smp.size(), 0);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout reached required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
